// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the RISC5 execute-path shift unit.
//   XLEN / SHW      : operand width and shift-count width
//   sh_op_e         : shift opcode encoding (2'b11 is reserved and behaves as ROR)
//   sh_req_t        : operand bundle held in stage A
//   lsl_rot_amt()   : converts a left-shift count into the equivalent right
//                     rotate amount for the shared rotator
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_ASR = 2'b01,
        SH_ROR = 2'b10,
        SH_RSV = 2'b11
    } sh_op_e;

    typedef struct packed {
        sh_op_e            op;
        logic [XLEN-1:0]   value;
        logic [SHW-1:0]    shcnt;
    } sh_req_t;

    // Rotating right by (32 - n) mod 32 is the same as rotating left by n.
    function automatic logic [SHW-1:0] lsl_rot_amt(input logic [SHW-1:0] cnt);
        return ~cnt + SHW'(1);
    endfunction

endpackage

// File: rtl/shift_unit_if.sv
// -----------------------------------------------------------------------------
// shift_unit_if
// Operand-side and result-side handshakes of the shift unit, plus flush.
//   master : the issuing / consuming side (execute control, writeback mux)
//   slave  : the shift unit itself
// Signals:
//   flush                          drop everything in flight
//   in_valid/in_ready              operand handshake
//   in_op/in_value/in_shcnt        operation, operand, shift count
//   out_valid/out_ready            result handshake
//   out_res/out_n/out_z            result and its N/Z flags
// -----------------------------------------------------------------------------
interface shift_unit_if;
    import cpu_pkg::*;

    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_op;
    logic [XLEN-1:0]     in_value;
    logic [SHW-1:0]      in_shcnt;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_res;
    logic                out_n;
    logic                out_z;

    modport master (
        output flush, in_valid, in_op, in_value, in_shcnt, out_ready,
        input  in_ready, out_valid, out_res, out_n, out_z
    );

    modport slave (
        input  flush, in_valid, in_op, in_value, in_shcnt, out_ready,
        output in_ready, out_valid, out_res, out_n, out_z
    );

endinterface

// File: rtl/ror.sv
// -----------------------------------------------------------------------------
// ror
// Purely combinational 32-bit rotate-right, built as a log2 barrel of
// conditional rotate-by-2^k stages.
//   value : operand
//   amt   : rotate amount, 0..31
//   rot   : value rotated right by amt
// -----------------------------------------------------------------------------
module ror
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] value,
    input  logic [SHW-1:0]  amt,
    output logic [XLEN-1:0] rot
);

    logic [SHW:0][XLEN-1:0] stg;

    assign stg[0] = value;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int S = 1 << k;
        assign stg[k+1] = amt[k] ? {stg[k][S-1:0], stg[k][XLEN-1:S]} : stg[k];
    end

    assign rot = stg[SHW];

endmodule

// File: rtl/shift_unit.sv
// -----------------------------------------------------------------------------
// shift_unit
// Two-stage pipelined LSL / ASR / ROR unit. Stage A registers the operand,
// the shared rotator plus fill masks sit between A and B, and stage B
// registers the result with its N/Z flags for the writeback mux.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   sh   : shift_unit_if.slave (operand handshake, result handshake, flush)
// -----------------------------------------------------------------------------
module shift_unit
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    shift_unit_if.slave   sh
);

    // Stage A
    logic             a_valid_q, a_valid_d;
    sh_req_t          a_q, a_d;

    // Stage B
    logic             b_valid_q, b_valid_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic             n_q, n_d;
    logic             z_q, z_d;

    // Handshake
    logic             b_adv;
    logic             in_ready;
    logic             a_load;
    logic             b_load;

    // Datapath between A and B
    logic [SHW-1:0]   rc;
    logic [XLEN-1:0]  rot;
    logic [XLEN-1:0]  lo_mask;
    logic [XLEN-1:0]  hi_mask;
    logic [XLEN-1:0]  sign_fill;
    logic [XLEN-1:0]  shift_res;

    // ---------------------------------------------------------------------
    // Handshake and pipeline control. in_ready depends only on state and
    // out_ready, never on in_valid.
    // ---------------------------------------------------------------------
    always_comb begin
        b_adv    = ~b_valid_q | sh.out_ready;
        in_ready = ~a_valid_q | b_adv;
        // A flush also refuses a same-cycle operand and freezes the data regs.
        a_load   = sh.in_valid & in_ready & ~sh.flush;
        b_load   = a_valid_q & b_adv & ~sh.flush;
    end

    // ---------------------------------------------------------------------
    // Rotate + mask datapath. The masks depend only on the count, so they
    // resolve in parallel with the rotator.
    // ---------------------------------------------------------------------
    always_comb begin
        rc = (a_q.op == SH_LSL) ? lsl_rot_amt(a_q.shcnt) : a_q.shcnt;
    end

    ror u_ror (
        .value (a_q.value),
        .amt   (rc),
        .rot   (rot)
    );

    always_comb begin
        // lo_mask: bits below the count; hi_mask: top `count` bits.
        // Both are zero when the count is zero.
        lo_mask   = ~({XLEN{1'b1}} << a_q.shcnt);
        hi_mask   = ~({XLEN{1'b1}} >> a_q.shcnt);
        sign_fill = {XLEN{a_q.value[XLEN-1]}};
        case (a_q.op)
            SH_LSL:  shift_res = rot & ~lo_mask;
            SH_ASR:  shift_res = (rot & ~hi_mask) | (hi_mask & sign_fill);
            default: shift_res = rot;   // ROR and the reserved encoding
        endcase
    end

    // ---------------------------------------------------------------------
    // Next-state
    // ---------------------------------------------------------------------
    always_comb begin
        a_valid_d = a_valid_q;
        a_d       = a_q;
        b_valid_d = b_valid_q;
        res_d     = res_q;
        n_d       = n_q;
        z_d       = z_q;

        if (sh.flush) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
        end else begin
            if (in_ready) a_valid_d = sh.in_valid;
            if (b_adv)    b_valid_d = a_valid_q;
        end

        if (a_load) begin
            a_d.op    = sh_op_e'(sh.in_op);
            a_d.value = sh.in_value;
            a_d.shcnt = sh.in_shcnt;
        end

        if (b_load) begin
            res_d = shift_res;
            n_d   = shift_res[XLEN-1];
            z_d   = (shift_res == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            a_q       <= '0;
            b_valid_q <= 1'b0;
            res_q     <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
        end else begin
            a_valid_q <= a_valid_d;
            a_q       <= a_d;
            b_valid_q <= b_valid_d;
            res_q     <= res_d;
            n_q       <= n_d;
            z_q       <= z_d;
        end
    end

    assign sh.in_ready  = in_ready;
    assign sh.out_valid = b_valid_q;
    assign sh.out_res   = res_q;
    assign sh.out_n     = n_q;
    assign sh.out_z     = z_q;

endmodule

// File: tb/tb_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_unit
// Self-checking bench for shift_unit: directed vector table, backpressure,
// full-throughput random stream, flush and mid-stream reset sequences.
// Expected results are queued on operand acceptance and popped on result
// transfer.
// -----------------------------------------------------------------------------
module tb_shift_unit;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] value;
        logic [4:0]  cnt;
        logic [31:0] res;
        logic        n;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        n;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    int   n_cmp = 0;
    int   n_err = 0;
    int   acc_cnt = 0;

    exp_t sb[$];
    int   pop_cyc[$];
    exp_t cur_exp;
    exp_t mon_e;

    shift_unit_if sh();

    shift_unit dut (
        .clk (clk),
        .rst (rst),
        .sh  (sh.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] v,
                                              input logic [4:0] s);
        case (op)
            2'b00:   return v << s;
            2'b01:   return 32'($signed(v) >>> s);
            default: return (s == 5'd0) ? v : ((v >> s) | (v << (6'd32 - {1'b0, s})));
        endcase
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] r);
        exp_t e;
        e.res = r;
        e.n   = r[31];
        e.z   = (r == 32'h0);
        return e;
    endfunction

    // Scoreboard: pop/compare on result transfer, push on operand acceptance.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (sh.out_valid && sh.out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got res=%h, required no result (cycle %0d)",
                             sh.out_res, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk ("out_res", sh.out_res, mon_e.res);
                    chk1("out_n",   sh.out_n,   mon_e.n);
                    chk1("out_z",   sh.out_z,   mon_e.z);
                    pop_cyc.push_back(cyc);
                end
            end
            if (sh.flush) begin
                sb.delete();
            end else if (sh.in_valid && sh.in_ready) begin
                sb.push_back(cur_exp);
                acc_cnt++;
            end
        end
    end

    // Offer one operand and hold it until accepted; returns the handshake
    // cycle. Called and returns at posedge+1.
    task automatic send(input logic [1:0] op, input logic [31:0] v, input logic [4:0] c,
                        input exp_t ex, output int acc);
        sh.in_valid = 1'b1;
        sh.in_op    = op;
        sh.in_value = v;
        sh.in_shcnt = c;
        cur_exp     = ex;
        acc         = -1;
        for (int i = 0; i < 40 && acc < 0; i++) begin
            @(negedge clk);
            if (sh.in_ready && !sh.flush) acc = cyc;
            @(posedge clk);
            #1;
        end
        if (acc < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no accept, required accept within 40 cycles");
        end
        sh.in_valid = 1'b0;
    endtask

    task automatic send_ref(input logic [1:0] op, input logic [31:0] v, input logic [4:0] c,
                            output int acc);
        send(op, v, c, mk_exp(ref_model(op, v, c)), acc);
    endtask

    task automatic drain(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !sh.out_valid) done = 1'b1;
        end
        @(posedge clk);
        #1;
        chki(nm, sb.size(), 0);
    endtask

    vec_t tbl[10];
    int   acc, acc0, acc_base, lat;
    exp_t e1, e2, e3;

    initial begin
        tbl[0] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1, 1'b0};
        tbl[1] = '{2'b01, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b1, 1'b0};
        tbl[2] = '{2'b10, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0, 1'b0};
        tbl[3] = '{2'b00, 32'h8000_0000, 5'd1,  32'h0000_0000, 1'b0, 1'b1};
        tbl[4] = '{2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b1, 1'b0};
        tbl[5] = '{2'b01, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0, 1'b1};
        tbl[6] = '{2'b01, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[7] = '{2'b10, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1, 1'b0};
        tbl[8] = '{2'b00, 32'hA5A5_A5A5, 5'd4,  32'h5A5A_5A50, 1'b0, 1'b0};
        tbl[9] = '{2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b0};

        rst          = 1'b1;
        sh.flush     = 1'b0;
        sh.in_valid  = 1'b0;
        sh.in_op     = 2'b00;
        sh.in_value  = 32'h0;
        sh.in_shcnt  = 5'd0;
        sh.out_ready = 1'b0;
        cur_exp      = mk_exp(32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_in_ready",  sh.in_ready,  1'b1);
        chk1("rst_out_valid", sh.out_valid, 1'b0);
        chk ("rst_out_res",   sh.out_res,   32'h0);
        chk1("rst_out_n",     sh.out_n,     1'b0);
        chk1("rst_out_z",     sh.out_z,     1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vector table, back-to-back
        sh.out_ready = 1'b1;
        foreach (tbl[i]) begin
            exp_t ex;
            ex.res = tbl[i].res;
            ex.n   = tbl[i].n;
            ex.z   = tbl[i].z;
            send(tbl[i].op, tbl[i].value, tbl[i].cnt, ex, acc);
        end
        drain("table_drain");

        // Backpressure: consumer stalled while three operands are offered
        sh.out_ready = 1'b0;
        e1 = mk_exp(32'h0000_FF00);
        e2 = mk_exp(32'hFFF0_0000);
        e3 = mk_exp(32'h1000_0000);
        acc_base = acc_cnt;
        send(2'b00, 32'h0000_00FF, 5'd8, e1, acc);
        send(2'b01, 32'hF000_0000, 5'd8, e2, acc);
        sh.in_valid = 1'b1;
        sh.in_op    = 2'b10;
        sh.in_value = 32'h0000_0001;
        sh.in_shcnt = 5'd4;
        cur_exp     = e3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("bp_in_ready",  sh.in_ready,  1'b0);
            chk1("bp_out_valid", sh.out_valid, 1'b1);
            chk ("bp_out_res",   sh.out_res,   e1.res);
        end
        chki("bp_accepted", acc_cnt - acc_base, 2);
        @(posedge clk);
        #1;
        sh.out_ready = 1'b1;
        send(2'b10, 32'h0000_0001, 5'd4, e3, acc);
        drain("bp_drain");

        // Full throughput: 16 random operands back-to-back
        pop_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            send_ref(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), acc);
            if (i == 0) acc0 = acc;
        end
        drain("tp_drain");
        chki("tp_count", pop_cyc.size(), 16);
        if (pop_cyc.size() == 16) begin
            chki("tp_first_latency", pop_cyc[0] - acc0, 2);
            chki("tp_consecutive",   pop_cyc[15] - pop_cyc[0], 15);
        end

        // Flush with both stages full and an operand offered
        sh.out_ready = 1'b0;
        send_ref(2'b00, 32'h1111_1111, 5'd3, acc);
        send_ref(2'b01, 32'h8888_0000, 5'd5, acc);
        sh.in_valid = 1'b1;
        sh.in_op    = 2'b10;
        sh.in_value = 32'h5555_AAAA;
        sh.in_shcnt = 5'd7;
        cur_exp     = mk_exp(32'hDEAD_0000);
        sh.flush    = 1'b1;
        @(posedge clk);
        #1;
        sh.flush    = 1'b0;
        sh.in_valid = 1'b0;
        @(negedge clk);
        chk1("flush_out_valid", sh.out_valid, 1'b0);
        chk1("flush_in_ready",  sh.in_ready,  1'b1);
        sh.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("flush_no_out", sh.out_valid, 1'b0);
        end

        // Flush while in_ready is high: the same-cycle operand is refused
        @(posedge clk);
        #1;
        sh.in_valid = 1'b1;
        sh.in_op    = 2'b00;
        sh.in_value = 32'h0000_0F0F;
        sh.in_shcnt = 5'd4;
        sh.flush    = 1'b1;
        @(posedge clk);
        #1;
        sh.flush    = 1'b0;
        sh.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("flush_refused", sh.out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // Reset mid-stream with both stages full
        sh.out_ready = 1'b0;
        send_ref(2'b10, 32'hCAFE_F00D, 5'd12, acc);
        send_ref(2'b00, 32'h0000_0003, 5'd9,  acc);
        rst = 1'b1;
        #1;
        chk1("mid_rst_out_valid", sh.out_valid, 1'b0);
        chk1("mid_rst_in_ready",  sh.in_ready,  1'b1);
        chk ("mid_rst_out_res",   sh.out_res,   32'h0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        sh.out_ready = 1'b1;
        send_ref(2'b00, 32'h0000_0003, 5'd2, acc);
        lat = -1;
        for (int i = 0; i < 10 && lat < 0; i++) begin
            if (i > 0 || 1'b1) begin
                @(negedge clk);
                if (sh.out_valid) lat = cyc - acc;
            end
        end
        chki("post_rst_latency", lat, 2);
        chk ("post_rst_res", sh.out_res, 32'h0000_000C);
        @(posedge clk);
        #1;
        drain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
